seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
// - Shares the 4-digit seven-segment display between NUM_REQ requesters, e.g. a debug counter,
//   a status code and a UART byte viewer.
// - Round-robin arbiter with a minimum on-screen hold time, so a value stays readable.
// - Drives val3..val0 of the seven-segment driver, which does the digit multiplexing.
// - Sits between the requesting blocks and that driver; does no segment decoding itself.
// PARAMETERS
// - NUM_REQ      4            number of requesters, 2..8
// - HOLD_CYCLES  100_000_000  minimum grant length in clk cycles (1 s at 100 MHz); must be >= 2
// PORTS
// - clk    in   1           system clock; all state changes on posedge
// - rst    in   1           asynchronous, active-high reset
// - req    in   NUM_REQ     req[i]=1: requester i wants the display; level-sensitive
// - data   in   16*NUM_REQ  data[16*i+15:16*i] = 4 hex digits of requester i, MSD in [15:12]
// - gnt    out  NUM_REQ     one-hot grant, all-zero when no owner; registered
// - owner  out  3           index of current/last owner; registered
// - active out  1           1 in GRANT or LINGER
// - val3   out  4           digit 3 to the display driver (= data[15:12] of owner); registered
// - val2   out  4           digit 2; registered
// - val1   out  4           digit 1; registered
// - val0   out  4           digit 0; registered
// BEHAVIOUR
// - Reset: all asynchronous.
//   - state=IDLE, gnt=0, owner=NUM_REQ-1, active=0, val3..val0=4'h0, hold_cnt=0.
// - States:
//   - IDLE: no owner.
//   - GRANT: owner holds req.
//   - LINGER: owner has dropped req, hold time not yet elapsed.
// - hold_cnt: width $clog2(HOLD_CYCLES).
//   - Clears to 0 on every new or renewed grant.
//   - Increments each cycle in GRANT/LINGER.
//   - expire = (hold_cnt == HOLD_CYCLES-1).
// - Pick: round-robin starting at (owner+1) mod NUM_REQ, wrapping.
//   - Pick search covers the live req vector.
//   - Reset value of owner makes requester 0 first priority after reset.
// - IDLE, any req set at edge E:
//   - at E: state=GRANT, gnt=onehot(pick), owner=pick, hold_cnt=0.
//   - val updates at E+1.
//   - Latency req->gnt = 1 cycle; req->val = 2 cycles.
// - GRANT: val3..val0 <= data[owner] every cycle, so the live value tracks.
// - GRANT, owner req=0, not expire:
//   - state=LINGER, gnt=0, active stays 1.
//   - val frozen at last loaded value.
// - LINGER: counter keeps running; owner re-raising req does NOT regain the grant early.
// - At expire (GRANT or LINGER), re-arbitrate over req:
//   - another requester set: grant it the next edge, hold_cnt=0, no gap cycle. Owner is lowest
//     priority because of the rotation.
//   - only the owner set: renew; gnt unchanged, hold_cnt=0, val keeps tracking.
//   - none set: state=IDLE, gnt=0, active=0; val holds last value, owner unchanged.
// - Owner drops req on the same edge as expire: treat as expire; owner excluded since req=0.
// - Requesters changing data while not granted have no effect on val.
// - gnt is never multi-hot.
// - gnt and val change only at grant/expire edges (val also tracks in GRANT).
// - Reset mid-grant: immediate return to reset values.
//   - The display shows 0000 while rst is high.
// STRUCTURE
// - seg_defs.vh (shared include):
//   - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_LINGER=2'd2.
//   - DIGIT_W=4, DIGITS=4.
// - Sub-module seg_rr_pick: combinational round-robin picker.
//   - Inputs: req, last index. Outputs: pick index, any.
//   - Reused by later shared-peripheral arbiters.
// - Top: FSM, hold counter, data mux and output registers. Instantiated beside the
//   seven-segment driver.
// TESTING (HOLD_CYCLES=4, NUM_REQ=4)
// - Reset then req=0001, data0=16'h1234 -> gnt=0001 after 1 cycle; val3..0=1,2,3,4 after 2 cycles.
// - req=0101 held:
//   - gnt 0001 for 4 cycles, then 0100 for 4, then 0001 again.
//   - No cycle with gnt=0 between grants.
// - Owner0 drops req after 1 cycle, data0 then changes to BEEF:
//   - gnt=0 and active=1; val stays 1234 until expire.
//   - Then IDLE, active=0, val still 1234.
// - Single requester 3 held for 12 cycles, data3 counting:
//   - gnt=1000 continuously (renewals).
//   - val tracks data3 with 1-cycle lag.
// - req=1111 simultaneously from reset:
//   - Grant order 0,1,2,3,0.
//   - Each grant lasts exactly 4 cycles.
// - rst pulsed mid-GRANT -> same cycle gnt=0, val=0000, active=0; after release, re-grant
//   from requester 0.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter.
// FSM state encoding and display digit geometry.
package seg_display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LINGER = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: first set req after 'last', wrapping.
// 'last' itself is the lowest priority.
module seg_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last,
  output logic [2:0]         pick,
  output logic               any
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Scan farthest-first so the nearest hit overwrites earlier ones.
  always_comb begin
    pick = last;
    any  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % NUM_REQ)]) begin
        pick = 3'((int'(last) + k) % NUM_REQ);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 4-digit display with a minimum hold time.
// Feeds val3..val0 of the seven-segment driver.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [DIGIT_W*DIGITS*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [2:0]                     owner,
  output logic                           active,
  output logic [DIGIT_W-1:0]             val3,
  output logic [DIGIT_W-1:0]             val2,
  output logic [DIGIT_W-1:0]             val1,
  output logic [DIGIT_W-1:0]             val0
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam int DW = DIGIT_W * DIGITS;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [2:0]         owner_n;
  logic [2:0]         pick;
  logic               any;
  logic               expire;
  logic               own_req;
  logic [DW-1:0]      words [NUM_REQ];
  logic [DW-1:0]      val_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = data[DW*i +: DW];
  end

  seg_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req (req),
    .last(owner),
    .pick(pick),
    .any (any)
  );

  assign expire  = (cnt == CW'(HOLD_CYCLES - 1));
  assign own_req = req[owner[IW-1:0]];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gnt_n   = gnt;
    owner_n = owner;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          state_n = ST_GRANT;
          gnt_n   = NUM_REQ'(1) << pick;
          owner_n = pick;
          cnt_n   = '0;
        end
      end
      ST_GRANT, ST_LINGER: begin
        if (expire) begin
          // Rotation makes the current owner lowest priority.
          if (any) begin
            state_n = ST_GRANT;
            gnt_n   = NUM_REQ'(1) << pick;
            owner_n = pick;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
          end
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
          if (state == ST_GRANT && !own_req) begin
            state_n = ST_LINGER;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      gnt   <= '0;
      owner <= 3'(NUM_REQ - 1);
      val_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      owner <= owner_n;
      if (state == ST_GRANT)
        val_q <= words[owner[IW-1:0]];
    end
  end

  assign active = (state != ST_IDLE);
  assign {val3, val2, val1, val0} = val_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural ownership model.
module tb_seg_display_arbiter;

  localparam int N = 4;
  localparam int H = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] data = '0;
  logic [N-1:0]    gnt;
  logic [2:0]      owner;
  logic            active;
  logic [3:0]      val3, val2, val1, val0;

  seg_display_arbiter #(
    .NUM_REQ(N),
    .HOLD_CYCLES(H)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .owner (owner),
    .active(active),
    .val3  (val3),
    .val2  (val2),
    .val1  (val1),
    .val0  (val0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the screen, for how long, and whether
  // the owner has let go.
  int          m_own;
  bit          m_busy;
  bit          m_lin;
  int          m_age;
  logic [15:0] m_val;

  function automatic int rr(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own  <= N - 1;
      m_busy <= 1'b0;
      m_lin  <= 1'b0;
      m_age  <= 0;
      m_val  <= '0;
    end else begin
      if (m_busy && !m_lin) m_val <= data[16*m_own +: 16];
      if (!m_busy) begin
        if (rr(m_own, req) >= 0) begin
          m_own  <= rr(m_own, req);
          m_busy <= 1'b1;
          m_age  <= 0;
          m_lin  <= 1'b0;
        end
      end else if (m_age == H - 1) begin
        m_age <= 0;
        m_lin <= 1'b0;
        if (rr(m_own, req) >= 0) m_own <= rr(m_own, req);
        else m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (!req[m_own]) m_lin <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = (m_busy && !m_lin) ? N'(1) << m_own : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("owner", 32'(owner), 32'(m_own));
    chk("active", 32'(active), 32'(m_busy));
    chk("val", 32'({val3, val2, val1, val0}), 32'(m_val));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] d3;

    // Reset state and first-grant latency.
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_val", 32'({val3, val2, val1, val0}), 32'h0);
    req = 4'b0001;
    data[15:0] = 16'h1234;
    tick();
    chk("lat_gnt", 32'(gnt), 32'h1);
    tick();
    chk("lat_val", 32'({val3, val2, val1, val0}), 32'h1234);

    // Two requesters alternate with no gap.
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("alt_gnt", 32'(gnt), (i < 4 || i >= 8) ? 32'h1 : 32'h4);
    end

    // Owner lets go early: linger with frozen value, then idle.
    do_reset();
    req = 4'b0001;
    data[15:0] = 16'h1234;
    tick();
    req = 4'b0000;
    tick();
    data[15:0] = 16'hBEEF;
    chk("lin_gnt", 32'(gnt), 32'h0);
    chk("lin_active", 32'(active), 32'h1);
    chk("lin_val", 32'({val3, val2, val1, val0}), 32'h1234);
    tick();
    tick();
    tick();
    chk("idle_active", 32'(active), 32'h0);
    chk("idle_val", 32'({val3, val2, val1, val0}), 32'h1234);

    // Lone requester renews and its value tracks.
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      d3 = 16'(16'hA000 + i * 16'h0111);
      data[63:48] = d3;
      tick();
      chk("ren_gnt", 32'(gnt), 32'h8);
      if (i > 0) chk("ren_val", 32'({val3, val2, val1, val0}), 32'(d3));
    end

    // All four requesting: strict rotation, 4 cycles each.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("rot_gnt", 32'(gnt), 32'(1) << ((i / 4) % 4));
    end

    // Reset in the middle of a grant.
    tick();
    rst = 1'b1;
    #1;
    chk("mid_gnt", 32'(gnt), 32'h0);
    chk("mid_val", 32'({val3, val2, val1, val0}), 32'h0);
    chk("mid_active", 32'(active), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_regnt", 32'(gnt), 32'h1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) req = N'($urandom);
      data = {$urandom, $urandom};
      tick();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
